// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS front-end types and constants for the fetch/decode buffer
package mips_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fdb_entry_t;

    typedef enum logic [1:0] {
        FDB_EMPTY,
        FDB_PARTIAL,
        FDB_FULL
    } fdb_state_e;

endpackage

// File: rtl/fdb_mem.sv
// rtl/fdb_mem.sv - DEPTH x fdb_entry_t register array, one sync write port, one async read port
module fdb_mem
    import mips_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_wr_en,
    input  logic [AW-1:0]   i_wr_addr,
    input  fdb_entry_t      i_wr_data,
    input  logic [AW-1:0]   i_rd_addr,
    output fdb_entry_t      o_rd_data
);

    fdb_entry_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fetch_decode_buffer.sv
// rtl/fetch_decode_buffer.sv - in-order fetch-to-decode queue with flush and NOP fill
// Optional FDB_BYPASS_EN: zero-latency pass-through of fetch data while the queue is empty.
module fetch_decode_buffer #(
    parameter int              DEPTH     = 2,
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_fetch_valid,
    input  logic [XLEN-1:0] i_fetch_pc,
    input  logic [XLEN-1:0] i_fetch_instr,
    output logic            o_fetch_ready,
    input  logic            i_flush,
    output logic            o_dec_valid,
    output logic [XLEN-1:0] o_dec_pc,
    output logic [XLEN-1:0] o_dec_pc4,
    output logic [XLEN-1:0] o_dec_instr,
    input  logic            i_dec_ready
);
    import mips_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fdb_state_e      r_state;
    logic [CW-1:0]   r_count;
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;

    logic            w_empty;
    logic            w_full;
    logic            w_bypass_show;
    logic            w_bypass_take;
    logic            w_push;
    logic            w_pop;
    logic [CW-1:0]   w_count_nxt;
    fdb_entry_t      w_wr_entry;
    fdb_entry_t      w_rd_entry;

    assign w_empty = (r_state == FDB_EMPTY);
    assign w_full  = (r_state == FDB_FULL);

    // Ready looks only at registered occupancy so fetch never sees a path from decode.
    assign o_fetch_ready = !w_full && !i_rst;

`ifdef FDB_BYPASS_EN
    assign w_bypass_show = w_empty && i_fetch_valid && !i_flush && !i_rst;
    assign w_bypass_take = w_bypass_show && i_dec_ready;
`else
    assign w_bypass_show = 1'b0;
    assign w_bypass_take = 1'b0;
`endif

    assign o_dec_valid = (!w_empty || w_bypass_show) && !i_flush && !i_rst;

    // A bypassed word is consumed directly, so it neither enters nor leaves storage.
    assign w_push = i_fetch_valid && o_fetch_ready && !i_flush && !w_bypass_take;
    assign w_pop  = o_dec_valid && i_dec_ready && !w_bypass_take;

    assign w_wr_entry.pc    = i_fetch_pc;
    assign w_wr_entry.instr = i_fetch_instr;

    fdb_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_entry)
    );

    always_comb begin
        o_dec_pc    = '0;
        o_dec_instr = NOP_INSTR;
        if (o_dec_valid) begin
            if (w_bypass_show) begin
                o_dec_pc    = i_fetch_pc;
                o_dec_instr = i_fetch_instr;
            end else begin
                o_dec_pc    = w_rd_entry.pc;
                o_dec_instr = w_rd_entry.instr;
            end
        end
    end

    assign o_dec_pc4 = o_dec_pc + XLEN'(4);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_state  <= FDB_EMPTY;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_count <= w_count_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_count_nxt == '0) begin
                r_state <= FDB_EMPTY;
            end else if (w_count_nxt == CW'(DEPTH)) begin
                r_state <= FDB_FULL;
            end else begin
                r_state <= FDB_PARTIAL;
            end
        end
    end

endmodule
